// File: rtl/scan_chain_ctrl.sv
// Load/capture/unload sequencer for a single mux-D scan chain.
// SE and SI are registered from the next state so they hold steady for the whole cycle of each state.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN  = 16,
   parameter int CAP_CYCLES = 1,
   parameter int CNT_W      = 8
) (
   input  logic                 CK,
   input  logic                 RN,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CHAIN_LEN-1:0] pattern_in,
   input  logic                 SO,
   output logic                 SE,
   output logic                 SI,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response
);

   typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(CAP_CYCLES - 1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [CHAIN_LEN-1:0] pat_q, pat_nx;
   logic [CHAIN_LEN-1:0] cap_q, cap_nx;
   logic [CHAIN_LEN-1:0] resp_nx;
   logic                 se_nx, si_nx, busy_nx, done_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      pat_nx   = pat_q;
      cap_nx   = cap_q;
      resp_nx  = response;
      si_nx    = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (start) begin
               state_nx = LOAD;
               pat_nx   = pattern_in;
               si_nx    = pattern_in[CHAIN_LEN-1];
            end
         end
         LOAD: begin
            // MSB first: after CHAIN_LEN shifts pattern bit i sits in flop i
            if (cnt == LAST_SHIFT) begin
               state_nx = CAPTURE;
               cnt_nx   = '0;
            end else begin
               pat_nx = pat_q << 1;
               si_nx  = pat_q[CHAIN_LEN-2];
            end
         end
         CAPTURE: begin
            if (cnt == LAST_CAP) begin
               state_nx = UNLOAD;
               cnt_nx   = '0;
            end
         end
         UNLOAD: begin
            // first SO sample is flop CHAIN_LEN-1, so it ends up in the MSB
            cap_nx = {cap_q[CHAIN_LEN-2:0], SO};
            if (cnt == LAST_SHIFT) begin
               state_nx = DONE;
               cnt_nx   = '0;
               resp_nx  = cap_nx;
            end
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      if (abort && (state == LOAD || state == CAPTURE || state == UNLOAD)) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         si_nx    = 1'b0;
         resp_nx  = response;
      end

      se_nx   = (state_nx == LOAD) || (state_nx == UNLOAD);
      busy_nx = se_nx || (state_nx == CAPTURE);
      done_nx = (state_nx == DONE);
   end

   always_ff @(posedge CK) begin
      if (!RN) begin
         state    <= IDLE;
         cnt      <= '0;
         pat_q    <= '0;
         cap_q    <= '0;
         response <= '0;
         SE       <= 1'b0;
         SI       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         pat_q    <= pat_nx;
         cap_q    <= cap_nx;
         response <= resp_nx;
         SE       <= se_nx;
         SI       <= si_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural chains, a scoreboard of expected responses and done cycles.
module tb_scan_chain_ctrl;

   typedef struct {
      logic [15:0] resp;
      int          cyc;
   } exp_t;

   logic        CK = 1'b0;
   logic        RN = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] pattern_in = '0;
   logic        SO, SE, SI, busy, done;
   logic [15:0] response;
   logic [15:0] chain = '0;

   logic        start2 = 1'b0;
   logic [1:0]  pattern2 = 2'b10;
   logic        SO2, SE2, SI2, busy2, done2;
   logic [1:0]  response2;
   logic [1:0]  chain2 = '0;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t q2[$];

   scan_chain_ctrl #(.CHAIN_LEN(16), .CAP_CYCLES(1), .CNT_W(8)) dut (
      .CK(CK), .RN(RN), .start(start), .abort(abort), .pattern_in(pattern_in),
      .SO(SO), .SE(SE), .SI(SI), .busy(busy), .done(done), .response(response)
   );

   scan_chain_ctrl #(.CHAIN_LEN(2), .CAP_CYCLES(3), .CNT_W(4)) dut2 (
      .CK(CK), .RN(RN), .start(start2), .abort(1'b0), .pattern_in(pattern2),
      .SO(SO2), .SE(SE2), .SI(SI2), .busy(busy2), .done(done2), .response(response2)
   );

   always #5 CK = ~CK;

   // chain 1 captures ~Q, chain 2 captures Q
   assign SO  = chain[15];
   assign SO2 = chain2[1];
   always @(posedge CK) begin
      chain  <= SE  ? {chain[14:0], SI}  : ~chain;
      chain2 <= SE2 ? {chain2[0], SI2}   : chain2;
      cyc    <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge CK) begin
      if (done) begin
         if (q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("response", {16'h0, response}, {16'h0, e.resp});
            chk("done_cyc", cyc, e.cyc);
         end
      end
      if (done2) begin
         if (q2.size() == 0) chk("done2_unexpected", 1, 0);
         else begin
            exp_t e;
            e = q2.pop_front();
            chk("response2", {30'h0, response2}, {16'h0, e.resp});
            chk("done2_cyc", cyc, e.cyc);
         end
      end
   end

   // start sampled at the edge after which cyc == e0; cycle n is observed at cyc == e0+n-1
   task automatic go(input logic [15:0] pat, input bit push, input logic [15:0] exp_resp,
                     output int e0);
      @(negedge CK);
      pattern_in = pat;
      start = 1'b1;
      @(posedge CK);
      #1;
      e0 = cyc;
      start = 1'b0;
      if (push) q.push_back('{exp_resp, e0 + 33});
   endtask

   initial begin
      int e0;
      int nbusy;
      logic [15:0] pat;

      repeat (3) @(posedge CK);
      @(negedge CK);
      chk("rst_se", SE, 0);
      chk("rst_si", SI, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_resp", response, 0);
      RN = 1'b1;

      // full sequence, waveform of SE/SI/busy
      pat = 16'hA5C3;
      go(pat, 1, 16'h5A3C, e0);
      for (int n = 1; n <= 35; n++) begin
         @(negedge CK);
         chk("se_wave", SE, ((n >= 1 && n <= 16) || (n >= 18 && n <= 33)) ? 1 : 0);
         chk("busy_wave", busy, (n <= 33) ? 1 : 0);
         if (n <= 16) chk("si_wave", SI, pat[16-n]);
      end
      chk("resp_hold", response, 16'h5A3C);

      // serial order
      go(16'h8000, 1, 16'h7FFF, e0);
      for (int n = 1; n <= 16; n++) begin
         @(negedge CK);
         chk("si_serial", SI, (n == 1) ? 1 : 0);
      end
      @(negedge CK);
      chk("chain_loaded", chain, 16'h8000);
      repeat (20) @(negedge CK);

      // start held for 80 edges: two full sequences plus a third begun at edge e0+70
      @(negedge CK);
      pattern_in = 16'hA5C3;
      start = 1'b1;
      @(posedge CK);
      #1;
      e0 = cyc;
      q.push_back('{16'h5A3C, e0 + 33});
      q.push_back('{16'h5A3C, e0 + 68});
      q.push_back('{16'h5A3C, e0 + 103});
      repeat (79) @(posedge CK);
      #1;
      start = 1'b0;
      repeat (30) @(negedge CK);

      // abort in unload cycle 5 (cycle 23)
      go(16'h1234, 0, 16'h0, e0);
      repeat (23) @(negedge CK);
      abort = 1'b1;
      @(negedge CK);
      abort = 1'b0;
      chk("abort_se", SE, 0);
      chk("abort_si", SI, 0);
      chk("abort_busy", busy, 0);
      chk("abort_resp", response, 16'h5A3C);
      repeat (20) @(negedge CK);
      chk("abort_resp_later", response, 16'h5A3C);

      // reset during capture, then a fresh sequence
      go(16'h1234, 0, 16'h0, e0);
      repeat (17) @(negedge CK);
      chk("cap_se", SE, 0);
      chk("cap_busy", busy, 1);
      RN = 1'b0;
      @(negedge CK);
      RN = 1'b1;
      chk("rn_se", SE, 0);
      chk("rn_busy", busy, 0);
      chk("rn_done", done, 0);
      chk("rn_resp", response, 0);
      go(16'hA5C3, 1, 16'h5A3C, e0);
      nbusy = 0;
      for (int n = 1; n <= 36; n++) begin
         @(negedge CK);
         if (busy) nbusy++;
      end
      chk("busy_len", nbusy, 33);

      // short chain instance
      @(negedge CK);
      start2 = 1'b1;
      @(posedge CK);
      #1;
      start2 = 1'b0;
      q2.push_back('{16'h0002, cyc + 7});
      repeat (12) @(negedge CK);

      chk("sb_empty", q.size(), 0);
      chk("sb2_empty", q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
